// File: rtl/sm_hex_display_scan_pkg.sv
// Shared types and constants for the hex display scanner: active-high segment
// patterns ({g,f,e,d,c,b,a}) and the per-slot FSM state encoding.
package sm_hex_display_scan_pkg;

    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_ON   = 1'b1
    } scan_state_e;

    localparam logic [6:0] SEG_OFF = 7'h00;
    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h7C;
    localparam logic [6:0] SEG_C   = 7'h39;
    localparam logic [6:0] SEG_D   = 7'h5E;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_F   = 7'h71;

endpackage

// File: rtl/sm_hex_display_scan_if.sv
// Scanner bus: core-side value/dp/blank/enable in, GPIO-side segment and digit drive out.
interface sm_hex_display_scan_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic [DIGITS-1:0]     blank_in;
    logic [6:0]            seg;
    logic                  dp;
    logic [DIGITS-1:0]     dig;
    logic                  frame_start;

    modport master (
        output en, value, dp_in, blank_in,
        input  seg, dp, dig, frame_start
    );

    modport slave (
        input  en, value, dp_in, blank_in,
        output seg, dp, dig, frame_start
    );
endinterface

// File: rtl/sm_hex_display_scan_seg_decode.sv
// Combinational hex nibble to active-high 7-segment pattern {g,f,e,d,c,b,a}.
module sm_seg_decode
    import sm_hex_display_scan_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        unique case (nib_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/sm_hex_display_scan.sv
// Time-multiplexed N-digit hex 7-segment scanner with frame-coherent snapshot and dead time.
// Optional leading-zero blanking when SM_HEX_SCAN_LZB_EN is defined.
//
// state   | meaning
// ST_DEAD | slot start, all digit selects inactive (cnt < DEAD_CYCLES)
// ST_ON   | digit idx selected and driven from the shadow snapshot
module sm_hex_display_scan
    import sm_hex_display_scan_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int DEAD_CYCLES    = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sm_hex_display_scan_if.slave bus
);

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("sm_hex_display_scan: DIGITS must be 1..8");
    end
    if (SCAN_DIV < 2) begin : g_bad_div
        $error("sm_hex_display_scan: SCAN_DIV must be >= 2");
    end
    if (DEAD_CYCLES < 0 || DEAD_CYCLES >= SCAN_DIV) begin : g_bad_dead
        $error("sm_hex_display_scan: DEAD_CYCLES must be 0..SCAN_DIV-1");
    end

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_TC   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  DEAD_C   = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_INV  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_INV   = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] DIG_INV  = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam scan_state_e       ST_RST   = (DEAD_CYCLES == 0) ? ST_ON : ST_DEAD;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    scan_state_e         state_q;
    logic                first_q;
    logic [4*DIGITS-1:0] val_sh_q;
    logic [DIGITS-1:0]   dp_sh_q;
    logic [DIGITS-1:0]   blank_sh_q;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   dig_q, dig_d;
    logic                fs_q;

    logic                tick;
    logic                snap;
    logic [3:0]          nib_arr [DIGITS];
    logic [6:0]          dec_seg;

    assign tick  = (cnt_q == CNT_TC);
    // Snapshot on the wrapping tick, or on the very first enabled cycle after reset.
    assign snap  = bus.en && (first_q || (tick && idx_q == IDX_LAST));
    assign cnt_d = !bus.en ? cnt_q : (tick ? '0 : cnt_q + 1'b1);
    assign idx_d = !(bus.en && tick) ? idx_q : ((idx_q == IDX_LAST) ? '0 : idx_q + 1'b1);

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            nib_arr[i] = val_sh_q[4*i +: 4];
        end
    end

    sm_seg_decode u_dec (
        .nib_i (nib_arr[idx_q]),
        .seg_o (dec_seg)
    );

`ifdef SM_HEX_SCAN_LZB_EN
    logic [DIGITS-1:0] lz_dark;

    always_comb begin
        logic seen;
        seen    = 1'b0;
        lz_dark = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen       = seen | (nib_arr[i] != 4'h0);
            lz_dark[i] = !seen && (i != 0);
        end
    end
`endif

    always_comb begin
        seg_d = SEG_OFF;
        dp_d  = 1'b0;
        dig_d = '0;
        if (bus.en && state_q == ST_ON) begin
            dig_d = DIGITS'(1) << idx_q;
            if (!blank_sh_q[idx_q]) begin
                seg_d = dec_seg;
                dp_d  = dp_sh_q[idx_q];
`ifdef SM_HEX_SCAN_LZB_EN
                if (lz_dark[idx_q]) begin
                    seg_d = SEG_OFF;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            state_q    <= ST_RST;
            first_q    <= 1'b1;
            val_sh_q   <= '0;
            dp_sh_q    <= '0;
            blank_sh_q <= '0;
            seg_q      <= SEG_INV;
            dp_q       <= DP_INV;
            dig_q      <= DIG_INV;
            fs_q       <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            if (bus.en) begin
                unique case (state_q)
                    ST_DEAD: if (cnt_d >= DEAD_C) state_q <= ST_ON;
                    ST_ON:   if (tick && DEAD_C != '0) state_q <= ST_DEAD;
                endcase
            end
            if (snap) begin
                first_q    <= 1'b0;
                val_sh_q   <= bus.value;
                dp_sh_q    <= bus.dp_in;
                blank_sh_q <= bus.blank_in;
            end
            // Polarity is applied only here; everything upstream is active-high.
            seg_q <= seg_d ^ SEG_INV;
            dp_q  <= dp_d ^ DP_INV;
            dig_q <= dig_d ^ DIG_INV;
            fs_q  <= snap;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.dig         = dig_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_sm_hex_display_scan.sv
// Bench for sm_hex_display_scan (DIGITS=4, SCAN_DIV=8, DEAD_CYCLES=2, active-low segments).
// Expectations follow SM_HEX_SCAN_LZB_EN when it is defined for the build.
module tb_sm_hex_display_scan;

    localparam int ND    = 4;
    localparam int SD    = 8;
    localparam int DC    = 2;
    localparam int FRAME = ND * SD;
`ifdef SM_HEX_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
    localparam logic [6:0] Z1 = 7'h7F;
`else
    localparam bit LZB = 1'b0;
    localparam logic [6:0] Z1 = 7'h40;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sm_hex_display_scan_if #(.DIGITS(ND)) bus ();

    sm_hex_display_scan #(
        .DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYCLES(DC),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model: position within the frame plus the latched snapshot.
    int          m_t;
    bit          m_first;
    logic [15:0] m_val;
    logic [3:0]  m_dp, m_blk;

    string hex_pat [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] r;
        string s;
        r = '0;
        s = hex_pat[n];
        for (int i = 0; i < s.len(); i++) begin
            r[s[i] - 8'h61] = 1'b1;
        end
        return r;
    endfunction

    function automatic int highest_nz(input logic [15:0] v);
        int h;
        h = 0;
        for (int i = 0; i < ND; i++) begin
            if (v[4*i +: 4] != 4'h0) h = i;
        end
        return h;
    endfunction

    function automatic logic [12:0] outs();
        return {bus.seg, bus.dp, bus.dig, bus.frame_start};
    endfunction

    task automatic check(input string nm, input logic [12:0] act, input logic [12:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got seg=%h dp=%b dig=%b fs=%b, want seg=%h dp=%b dig=%b fs=%b",
                     nm, $time, act[12:6], act[5], act[4:1], act[0], exp[12:6], exp[5], exp[4:1], exp[0]);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_first = 1'b1; m_val = '0; m_dp = '0; m_blk = '0;
    endtask

    task automatic step();
        logic [6:0] es, lit;
        logic       edp;
        logic [3:0] ed;
        logic       efs;
        int         slot, w;
        @(posedge clk);
        es = 7'h7F; edp = 1'b1; ed = '0; efs = 1'b0;
        if (bus.en) begin
            slot = m_t / SD;
            w    = m_t % SD;
            if (w >= DC) begin
                ed = 4'(1 << slot);
                if (!m_blk[slot]) begin
                    lit = seg_of(m_val[slot*4 +: 4]);
                    if (LZB && slot > highest_nz(m_val)) lit = '0;
                    es  = ~lit;
                    edp = ~m_dp[slot];
                end
            end
            if (m_first || m_t == FRAME - 1) begin
                efs = 1'b1; m_first = 1'b0;
                m_val = bus.value; m_dp = bus.dp_in; m_blk = bus.blank_in;
            end
            m_t = (m_t + 1) % FRAME;
        end
        #1;
        check("model", outs(), {es, edp, ed, efs});
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 check("async_reset", outs(), {7'h7F, 1'b1, 4'b0000, 1'b0});
        bus.en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        int          ncyc;
        logic        en;
        logic [15:0] value;
        logic [3:0]  dp_in;
        logic [3:0]  blank;
        logic [6:0]  seg;
        logic        dp;
        logic [3:0]  dig;
        logic        fs;
    } vec_t;

    vec_t tbl [17];

    initial begin
        tbl[0]  = '{1,  1'b1, 16'h1A3F, 4'b0000, 4'b0000, 7'h7F, 1'b1, 4'b0000, 1'b1};
        tbl[1]  = '{1,  1'b1, 16'h1A3F, 4'b0000, 4'b0000, 7'h7F, 1'b1, 4'b0000, 1'b0};
        tbl[2]  = '{1,  1'b1, 16'h1A3F, 4'b0000, 4'b0000, 7'h0E, 1'b1, 4'b0001, 1'b0};
        tbl[3]  = '{5,  1'b1, 16'h1A3F, 4'b0000, 4'b0000, 7'h0E, 1'b1, 4'b0001, 1'b0};
        tbl[4]  = '{1,  1'b1, 16'h1A3F, 4'b0000, 4'b0000, 7'h7F, 1'b1, 4'b0000, 1'b0};
        tbl[5]  = '{2,  1'b1, 16'h1A3F, 4'b0000, 4'b0000, 7'h30, 1'b1, 4'b0010, 1'b0};
        tbl[6]  = '{8,  1'b1, 16'h1A3F, 4'b0000, 4'b0000, 7'h08, 1'b1, 4'b0100, 1'b0};
        tbl[7]  = '{8,  1'b1, 16'h1A3F, 4'b0000, 4'b0000, 7'h79, 1'b1, 4'b1000, 1'b0};
        tbl[8]  = '{5,  1'b1, 16'h0000, 4'b0000, 4'b0000, 7'h79, 1'b1, 4'b1000, 1'b1};
        tbl[9]  = '{3,  1'b1, 16'h0000, 4'b0001, 4'b0100, 7'h40, 1'b1, 4'b0001, 1'b0};
        tbl[10] = '{8,  1'b1, 16'h0000, 4'b0001, 4'b0100, Z1,    1'b1, 4'b0010, 1'b0};
        tbl[11] = '{8,  1'b1, 16'h0000, 4'b0001, 4'b0100, Z1,    1'b1, 4'b0100, 1'b0};
        tbl[12] = '{8,  1'b1, 16'h0000, 4'b0001, 4'b0100, Z1,    1'b1, 4'b1000, 1'b0};
        tbl[13] = '{5,  1'b1, 16'h0000, 4'b0001, 4'b0100, Z1,    1'b1, 4'b1000, 1'b1};
        tbl[14] = '{3,  1'b1, 16'h0000, 4'b0001, 4'b0100, 7'h40, 1'b0, 4'b0001, 1'b0};
        tbl[15] = '{16, 1'b1, 16'h0000, 4'b0001, 4'b0100, 7'h7F, 1'b1, 4'b0100, 1'b0};
        tbl[16] = '{8,  1'b1, 16'h0000, 4'b0001, 4'b0100, Z1,    1'b1, 4'b1000, 1'b0};

        bus.en = 1'b0; bus.value = '0; bus.dp_in = '0; bus.blank_in = '0;
        model_reset();
        do_reset();

        for (int r = 0; r < 17; r++) begin
            bus.en = tbl[r].en; bus.value = tbl[r].value;
            bus.dp_in = tbl[r].dp_in; bus.blank_in = tbl[r].blank;
            repeat (tbl[r].ncyc) step();
            check($sformatf("tbl%0d", r), outs(), {tbl[r].seg, tbl[r].dp, tbl[r].dig, tbl[r].fs});
        end

        // en dropped mid-slot1 for 20 cycles, then slot1 finishes its remaining cycles.
        do_reset();
        bus.value = 16'h1A3F; bus.dp_in = '0; bus.blank_in = '0; bus.en = 1'b1;
        repeat (12) step();
        bus.en = 1'b0;
        step();
        check("en0_first", outs(), {7'h7F, 1'b1, 4'b0000, 1'b0});
        repeat (19) step();
        check("en0_last", outs(), {7'h7F, 1'b1, 4'b0000, 1'b0});
        bus.en = 1'b1;
        step();
        check("resume", outs(), {7'h30, 1'b1, 4'b0010, 1'b0});
        repeat (3) step();
        check("resume_end", outs(), {7'h30, 1'b1, 4'b0010, 1'b0});
        step();
        check("slot2_dead", outs(), {7'h7F, 1'b1, 4'b0000, 1'b0});
        repeat (2) step();
        check("slot2_on", outs(), {7'h08, 1'b1, 4'b0100, 1'b0});

        // Leading-zero case from the directed list, then randomized traffic against the model.
        do_reset();
        bus.value = 16'h0042; bus.dp_in = 4'b1000; bus.en = 1'b1;
        repeat (2 * FRAME) step();

        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) do_reset();
            bus.en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: bus.value = 16'($urandom);
                    1: bus.value = 16'($urandom) & 16'h00FF;
                    2: bus.value = 16'($urandom) & 16'h000F;
                    default: bus.value = 16'h0000;
                endcase
                bus.dp_in    = 4'($urandom);
                bus.blank_in = 4'($urandom) & 4'($urandom);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
